// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op codes, flag indices and FSM states for the segmented adder
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_ADC  = 3'd2,
    OP_SBC  = 3'd3,
    OP_ADDS = 3'd4,
    OP_SUBS = 3'd5
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } seg_state_e;

endpackage

// File: rtl/seg_adder.sv
// rtl/seg_adder.sv - combinational SEG_W-bit adder slice with carry in/out
module seg_adder #(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] i_a,
  input  logic [SEG_W-1:0] i_b,
  input  logic             i_cin,
  output logic [SEG_W-1:0] o_sum,
  output logic             o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SEG_W{1'b0}}, i_cin};

endmodule

// File: rtl/segmented_addsub.sv
// rtl/segmented_addsub.sv - multi-cycle add/subtract, one segment per clock, with flags and saturation
module segmented_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] bus_a_i,
  input  logic [WIDTH-1:0] bus_b_i,
  input  logic [2:0]       op_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] bus_o,
  output logic [3:0]       flags_o
);

  localparam int NSEG = WIDTH / SEG_W;
  localparam int KW   = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int MSB  = WIDTH - 1;
  localparam logic [KW-1:0] LAST_K = KW'(NSEG - 1);

  seg_state_e r_state, w_next;

  logic [WIDTH-1:0] r_a, r_b, r_raw, r_bus;
  logic [3:0]       r_flags;
  logic [KW-1:0]    r_k;
  logic             r_carry, r_sat;

  logic             w_accept, w_last;
  logic             w_sub, w_cin, w_sat;
  logic [SEG_W-1:0] w_sum;
  logic             w_cout, w_v;
  logic [WIDTH-1:0] w_raw, w_res;
  logic [3:0]       w_flags;

  // ready depends on ready_i only, never on valid_i
  assign ready_o  = (r_state == IDLE) | ((r_state == DONE) & ready_i);
  assign w_accept = valid_i & ready_o;
  assign w_last   = (r_k == LAST_K);

  assign valid_o = (r_state == DONE);
  assign bus_o   = r_bus;
  assign flags_o = r_flags;

  // decode op into operand inversion, carry-in and saturation enables
  always_comb begin
    w_sub = 1'b0;
    w_cin = 1'b0;
    w_sat = 1'b0;
    case (op_i)
      OP_SUB:  begin w_sub = 1'b1; w_cin = 1'b1; end
      OP_ADC:  begin w_cin = carry_i; end
      OP_SBC:  begin w_sub = 1'b1; w_cin = carry_i; end
      OP_ADDS: begin w_sat = 1'b1; end
      OP_SUBS: begin w_sub = 1'b1; w_cin = 1'b1; w_sat = 1'b1; end
      default: begin end
    endcase
  end

  // single slice adder, shared across segments by indexing on r_k
  seg_adder #(.SEG_W(SEG_W)) u_seg (
    .i_a    (r_a[int'(r_k)*SEG_W +: SEG_W]),
    .i_b    (r_b[int'(r_k)*SEG_W +: SEG_W]),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  // merge the current slice into the raw sum, then derive overflow, saturation and flags
  always_comb begin
    w_raw = r_raw;
    w_raw[int'(r_k)*SEG_W +: SEG_W] = w_sum;
    w_v   = (r_a[MSB] == r_b[MSB]) & (w_raw[MSB] != r_a[MSB]);
    w_res = w_raw;
    if (r_sat & w_v)
      w_res = r_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    w_flags         = 4'b0000;
    w_flags[FLAG_N] = w_res[MSB];
    w_flags[FLAG_Z] = (w_res == '0);
    w_flags[FLAG_C] = w_cout;
    w_flags[FLAG_V] = w_v;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = BUSY;
      BUSY:    if (w_last) w_next = DONE;
      DONE:    if (ready_i) w_next = valid_i ? BUSY : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // operand capture, per-segment accumulation and result/flag registration
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_raw   <= '0;
      r_bus   <= '0;
      r_flags <= '0;
      r_k     <= '0;
      r_carry <= 1'b0;
      r_sat   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus_a_i;
      r_b     <= w_sub ? ~bus_b_i : bus_b_i;
      r_carry <= w_cin;
      r_sat   <= w_sat;
      r_k     <= '0;
    end else if (r_state == BUSY) begin
      r_raw   <= w_raw;
      r_carry <= w_cout;
      r_k     <= r_k + KW'(1);
      if (w_last) begin
        r_bus   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_segmented_addsub.sv
// tb/tb_segmented_addsub.sv - randomized and directed self-checking bench for segmented_addsub
module tb_segmented_addsub;

  logic        clk_i, rst_i, valid_i, ready_o, carry_i, valid_o, ready_i;
  logic [15:0] bus_a_i, bus_b_i, bus_o;
  logic [2:0]  op_i;
  logic [3:0]  flags_o;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit mon_on = 0;

  typedef struct {
    logic [19:0] exp;
    int          acc;
  } exp_t;
  exp_t q[$];

  segmented_addsub #(.WIDTH(16), .SEG_W(4)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .bus_a_i (bus_a_i),
    .bus_b_i (bus_b_i),
    .op_i    (op_i),
    .carry_i (carry_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .bus_o   (bus_o),
    .flags_o (flags_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h expected=%h (t=%0t)", nm, got, exp, $time);
  endtask

  // reference: integer arithmetic for the raw sum, signed range test for overflow
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] op, input logic c);
    logic        sub, sat, cin, vv;
    logic [15:0] be, res;
    int          ua, sa;
    sub = (op == 3'd1) || (op == 3'd3) || (op == 3'd5);
    sat = (op == 3'd4) || (op == 3'd5);
    cin = (op == 3'd1 || op == 3'd5) ? 1'b1 : (op == 3'd2 || op == 3'd3) ? c : 1'b0;
    be  = sub ? ~b : b;
    ua  = int'(a) + int'(be) + int'(cin);
    sa  = int'($signed(a)) + int'($signed(be)) + int'(cin);
    vv  = (sa > 32767) || (sa < -32768);
    res = ua[15:0];
    if (sat && vv) res = (sa > 32767) ? 16'h7FFF : 16'h8000;
    return {res, res[15], (res == 16'h0000), ua[16], vv};
  endfunction

  // cycle-by-cycle comparison against the queued model results
  always @(negedge clk_i) begin
    logic ev, er;
    if (mon_on) begin
      if (rst_i) begin
        q.delete();
      end else begin
        ev = (q.size() > 0) && (cyc >= q[0].acc + 5);
        er = (q.size() == 0) ? 1'b1 : (ev ? ready_i : 1'b0);
        chk("mon_valid_o", 32'(valid_o), 32'(ev));
        chk("mon_ready_o", 32'(ready_o), 32'(er));
        if (ev) begin
          chk("mon_bus_o", 32'(bus_o), 32'(q[0].exp[19:4]));
          chk("mon_flags_o", 32'(flags_o), 32'(q[0].exp[3:0]));
        end
        if (ev && ready_i) void'(q.pop_front());
        if (valid_i && er) q.push_back('{model(bus_a_i, bus_b_i, op_i, carry_i), cyc});
      end
    end
  end

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid_o && n < 20) begin
      @(posedge clk_i); #1;
      n++;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                       input logic c, input logic [19:0] lit, input logic hold);
    int t, n;
    chk("model_pin", 32'(model(a, b, op, c)), 32'(lit));
    @(posedge clk_i); #1;
    bus_a_i = a; bus_b_i = b; op_i = op; carry_i = c;
    valid_i = 1'b1; ready_i = 1'b1;
    t = 0;
    while (!ready_o && t < 20) begin
      @(posedge clk_i); #1;
      t++;
    end
    chk("accept_wait", 32'(t < 20), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    bus_a_i = 16'($urandom); bus_b_i = 16'($urandom);
    op_i = 3'($urandom); carry_i = 1'($urandom);
    if (hold) ready_i = 1'b0;
    wait_valid(n);
    chk("latency", 32'(n), 32'd4);
    chk("dir_bus_o", 32'(bus_o), 32'(lit[19:4]));
    chk("dir_flags_o", 32'(flags_o), 32'(lit[3:0]));
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n, seen;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
    bus_a_i = '0; bus_b_i = '0; op_i = '0; carry_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    mon_on = 1'b1;
    @(negedge clk_i);
    chk("rst_ready_o", 32'(ready_o), 32'd1);
    chk("rst_valid_o", 32'(valid_o), 32'd0);
    chk("rst_bus_o", 32'(bus_o), 32'd0);
    chk("rst_flags_o", 32'(flags_o), 32'd0);

    do_op(16'h7FFF, 16'h0001, 3'd0, 1'b0, {16'h8000, 4'b1001}, 1'b0);
    do_op(16'h0005, 16'h0005, 3'd1, 1'b0, {16'h0000, 4'b0110}, 1'b0);
    do_op(16'h0003, 16'h0005, 3'd1, 1'b0, {16'hFFFE, 4'b1000}, 1'b0);
    do_op(16'hFFFF, 16'h0000, 3'd2, 1'b1, {16'h0000, 4'b0110}, 1'b0);
    do_op(16'h0010, 16'h0001, 3'd3, 1'b0, {16'h000E, 4'b0010}, 1'b0);
    do_op(16'h7FFF, 16'h0001, 3'd4, 1'b0, {16'h7FFF, 4'b0001}, 1'b0);
    do_op(16'h8000, 16'h0001, 3'd5, 1'b0, {16'h8000, 4'b1011}, 1'b0);
    do_op(16'h1234, 16'h0101, 3'd7, 1'b1, {16'h1335, 4'b0000}, 1'b0);

    // backpressure in DONE, then back-to-back accept on the release edge
    do_op(16'h1234, 16'h0101, 3'd0, 1'b0, {16'h1335, 4'b0000}, 1'b1);
    repeat (5) begin
      @(posedge clk_i); #1;
      chk("bp_valid_o", 32'(valid_o), 32'd1);
      chk("bp_bus_o", 32'(bus_o), 32'h1335);
      chk("bp_flags_o", 32'(flags_o), 32'd0);
      chk("bp_ready_o", 32'(ready_o), 32'd0);
    end
    bus_a_i = 16'h0003; bus_b_i = 16'h0005; op_i = 3'd1; carry_i = 1'b0;
    valid_i = 1'b1; ready_i = 1'b1;
    #1 chk("bp_release_ready_o", 32'(ready_o), 32'd1);
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    chk("b2b_valid_low", 32'(valid_o), 32'd0);
    wait_valid(n);
    chk("b2b_latency", 32'(n), 32'd4);
    chk("b2b_bus_o", 32'(bus_o), 32'hFFFE);

    // reset during the second BUSY cycle aborts the op
    @(posedge clk_i); #1;
    bus_a_i = 16'h00FF; bus_b_i = 16'h0001; op_i = 3'd0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("abort_valid_o", 32'(valid_o), 32'd0);
    chk("abort_bus_o", 32'(bus_o), 32'd0);
    chk("abort_flags_o", 32'(flags_o), 32'd0);
    chk("abort_ready_o", 32'(ready_o), 32'd1);
    seen = 0;
    repeat (8) begin
      @(posedge clk_i); #1;
      if (valid_o) seen++;
    end
    chk("abort_no_result", 32'(seen), 32'd0);

    // random traffic with random handshakes on both sides
    repeat (1500) begin
      @(posedge clk_i); #1;
      valid_i = 1'($urandom_range(0, 1));
      bus_a_i = pick(); bus_b_i = pick();
      op_i    = 3'($urandom_range(0, 7));
      carry_i = 1'($urandom);
      ready_i = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk_i); #1;
    valid_i = 1'b0; ready_i = 1'b1;
    repeat (12) @(posedge clk_i);
    #1 chk("drain_empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/segmented_addsub.md
# segmented_addsub

Multi-cycle, width-parametrised adder/subtractor for the ALU datapath. Computes one SEG_W-bit segment per clock with a registered carry between segments, so wide operands close timing without a long ripple chain. Supports plain, carry-in and signed-saturating modes, returns N/Z/C/V flags, and uses a valid/ready handshake on both sides. It replaces the single-cycle add/subtract unit wherever the ALU width exceeds one-cycle ripple timing.

## Interface
- WIDTH, 32: operand/result width; must be an integer multiple of SEG_W.
- SEG_W, 8: bits processed per cycle; NSEG = WIDTH/SEG_W.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  operands and op are valid.
- ready_o  out  1  block can accept; equals (state==IDLE) | (state==DONE & ready_i).
- bus_a_i  in  WIDTH  operand A.
- bus_b_i  in  WIDTH  operand B.
- op_i  in  3  operation, alu_op_e.
- carry_i  in  1  carry-in for ADC/SBC; ignored otherwise.
- valid_o  out  1  result and flags valid.
- ready_i  in  1  downstream accepts the result.
- bus_o  out  WIDTH  result.
- flags_o  out  4  {N,Z,C,V}.

## Operation
- Ops: ADD=0 (A+B), SUB=1 (A+~B+1), ADC=2 (A+B+carry_i), SBC=3 (A+~B+carry_i), ADDS=4 (ADD, signed saturate), SUBS=5 (SUB, signed saturate). Codes 6 and 7 execute as ADD.
- Accept when valid_i & ready_o. Latch A, the effective B (inverted for SUB/SBC/SUBS), cin and op. Clear segment index.
- FSM states:
  - IDLE: on accept go to BUSY.
  - BUSY: each cycle add segment k (LSBs first) with the registered carry, store the sum slice and carry, increment k. After segment NSEG-1 go to DONE.
  - DONE: hold the result. If ready_i & valid_i, accept a new op and go to BUSY. If ready_i & !valid_i, go to IDLE. If !ready_i, stay.
- Flags:
  - C is the carry out of the MSB. For subtraction, C=1 means no borrow.
  - V = (A[MSB]==B_eff[MSB]) & (raw[MSB]!=A[MSB]).
  - N = bus_o[MSB]; Z = (bus_o==0).
- Saturation (ADDS/SUBS only): if V=1, bus_o = 0x7F..F when A[MSB]=0, else 0x80..0. C and V are taken from the raw sum. N and Z are taken from the saturated bus_o.
- Arithmetic is modulo 2^WIDTH. No width extension.

## Timing
- Reset values: state IDLE, valid_o=0, bus_o=0, flags_o=0, internal carry/index 0. ready_o=1 in the cycle after reset.
- Reset in any state aborts the operation at that edge. No partial result is ever presented.
- Latency: valid_o rises exactly NSEG cycles after the accepting edge.
- Throughput: one op per NSEG+1 cycles, including back-to-back accept in DONE.
- valid_o, bus_o and flags_o are registered and stable while valid_o & !ready_i. They change only after the handshake edge.
- ready_o has a combinational path from ready_i only. There is no path from valid_i.
- Inputs are sampled only on the accepting edge. Changes to bus_a_i/bus_b_i/op_i/carry_i while BUSY have no effect.
- NSEG=1 is legal: BUSY lasts one cycle.

## Structure
- alu_pkg holds:
  - typedef enum logic [2:0] alu_op_e.
  - flag index localparams FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - typedef enum for FSM states seg_state_e {IDLE, BUSY, DONE}.
- One sub-module, seg_adder #(SEG_W): combinational SEG_W-bit add with cin, producing sum and cout. Instantiate it once and reuse it every cycle via a slice mux on index k.
- The top module owns the FSM, operand/result registers, saturation and flag logic.

## Test plan
All scenarios use WIDTH=16, SEG_W=4 (NSEG=4).
- ADD 0x7FFF+0x0001 -> bus_o=0x8000, flags N=1 Z=0 C=0 V=1; valid_o exactly 4 cycles after accept.
- SUB 0x0005-0x0005 -> 0x0000, N=0 Z=1 C=1 V=0. SUB 0x0003-0x0005 -> 0xFFFE, N=1 C=0 V=0.
- ADC 0xFFFF+0x0000, carry_i=1 -> 0x0000, Z=1 C=1 V=0. SBC 0x0010-0x0001, carry_i=0 -> 0x000E, C=1.
- ADDS 0x7FFF+0x0001 -> 0x7FFF, N=0 C=0 V=1. SUBS 0x8000-0x0001 -> 0x8000, N=1 C=1 V=1.
- Backpressure: ready_i=0 for 5 cycles in DONE -> bus_o/flags_o/valid_o constant and ready_o=0. Then ready_i=1 with valid_i=1 -> new op accepted on that edge and valid_o low the next cycle.
- rst_i pulsed during the 2nd BUSY cycle -> next cycle valid_o=0, bus_o=0, flags_o=0, ready_o=1. No result is emitted for the aborted op.
